// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_buffered : FIFO-buffered 8N1 UART transmitter, LSB first.
// Revision 1.0
// ---------------------------------------------------------------------------
module uart_tx_buffered #(
  parameter int CLK_DIV    = 434,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                i_CLK,
  input  logic                i_RST_N,
  input  logic [7:0]          i_Data8,
  input  logic                i_WR,
  input  logic                i_ClrOvf,
  output logic                o_TXD,
  output logic                o_Busy,
  output logic                o_Full,
  output logic                o_Empty,
  output logic [DEPTH_LOG2:0] o_Count,
  output logic                o_Overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]       c_BAUD_MAX = CW'(CLK_DIV - 1);
  localparam logic [DEPTH_LOG2:0] c_DEPTH    = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_ovf;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_baud;
  logic [CW-1:0]         w_baud_nxt;
  logic [2:0]            r_bit;
  logic [2:0]            w_bit_nxt;
  logic [7:0]            r_shift;
  logic [7:0]            w_shift_nxt;
  logic                  r_txd;
  logic                  w_txd_nxt;

  logic                  w_wr_acc;
  logic                  w_pop;
  logic                  w_bit_done;
  logic [7:0]            w_head;

  assign o_Full     = (r_count == c_DEPTH);
  assign o_Empty    = (r_count == '0);
  assign o_Count    = r_count;
  assign o_Overflow = r_ovf;
  assign o_TXD      = r_txd;
  assign o_Busy     = (r_state != S_IDLE);

  // A pop in the same cycle never frees a slot for a write while full.
  assign w_wr_acc   = i_WR & ~o_Full;
  assign w_head     = r_mem[r_rptr];
  assign w_bit_done = (r_baud == '0);

  always_ff @(posedge i_CLK) begin
    if (w_wr_acc) begin
      r_mem[r_wptr] <= i_Data8;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_wr_acc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_WR && o_Full) begin
        r_ovf <= 1'b1;
      end else if (i_ClrOvf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_txd   <= w_txd_nxt;
    end
  end

  // w_txd_nxt is the line level for the state being entered, so o_TXD
  // tracks r_state with no extra cycle of lag.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_txd_nxt   = 1'b1;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!o_Empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_baud_nxt  = c_BAUD_MAX;
          w_state_nxt = S_START;
          w_txd_nxt   = 1'b0;
        end
      end
      S_START: begin
        w_txd_nxt = 1'b0;
        if (w_bit_done) begin
          w_baud_nxt  = c_BAUD_MAX;
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
          w_txd_nxt   = r_shift[0];
        end else begin
          w_baud_nxt = r_baud - 1'b1;
        end
      end
      S_DATA: begin
        w_txd_nxt = r_shift[0];
        if (w_bit_done) begin
          w_baud_nxt  = c_BAUD_MAX;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
            w_txd_nxt   = 1'b1;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
            w_txd_nxt = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud - 1'b1;
        end
      end
      S_STOP: begin
        w_txd_nxt = 1'b1;
        if (w_bit_done) begin
          if (!o_Empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_baud_nxt  = c_BAUD_MAX;
            w_state_nxt = S_START;
            w_txd_nxt   = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// tb_uart_tx_buffered : directed + randomized checks against a frame-level model.
// Revision 1.0
module tb_uart_tx_buffered;

  localparam int D     = 4;
  localparam int DL    = 3;
  localparam int DEPTH = 1 << DL;
  localparam int FRAME = 10 * D;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          i_WR     = 1'b0;
  logic          i_ClrOvf = 1'b0;
  logic [7:0]    i_Data8  = 8'h00;
  logic          o_TXD, o_Busy, o_Full, o_Empty, o_Overflow;
  logic [DL:0]   o_Count;

  always #5 clk = ~clk;

  uart_tx_buffered #(.CLK_DIV(D), .DEPTH_LOG2(DL)) dut (
    .i_CLK      (clk),
    .i_RST_N    (rst_n),
    .i_Data8    (i_Data8),
    .i_WR       (i_WR),
    .i_ClrOvf   (i_ClrOvf),
    .o_TXD      (o_TXD),
    .o_Busy     (o_Busy),
    .o_Full     (o_Full),
    .o_Empty    (o_Empty),
    .o_Count    (o_Count),
    .o_Overflow (o_Overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a byte queue plus a cycle offset into the current frame.
  logic [7:0] m_q[$];
  logic [7:0] m_popped[$];
  logic       m_act = 1'b0;
  int         m_t   = 0;
  logic [7:0] m_cur = 8'h00;
  logic       m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic full, do_pop, do_wr;
    if (!rst_n) begin
      m_q.delete();
      m_act = 1'b0;
      m_t   = 0;
      m_ovf = 1'b0;
    end else begin
      full   = (m_q.size() == DEPTH);
      do_pop = (m_q.size() > 0) && (!m_act || m_t == FRAME - 1);
      do_wr  = i_WR && !full;
      if (i_WR && full) m_ovf = 1'b1;
      else if (i_ClrOvf) m_ovf = 1'b0;
      if (m_act) begin
        m_t++;
        if (m_t == FRAME) m_act = 1'b0;
      end
      if (do_pop) begin
        m_cur = m_q.pop_front();
        m_popped.push_back(m_cur);
        m_act = 1'b1;
        m_t   = 0;
      end
      if (do_wr) m_q.push_back(i_Data8);
    end
  end

  function automatic logic fbit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  logic [7:0] rx[$];
  int         d_cnt = -1;
  logic [7:0] d_byte = 8'h00;
  int         busy_cycles = 0;
  int         busy_falls  = 0;
  logic       prev_busy   = 1'b0;

  // Per-cycle compare plus a mid-bit sampling line decoder.
  always @(posedge clk) begin
    int k;
    #1;
    chk("txd",   o_TXD,      m_act ? fbit(m_cur, m_t / D) : 1'b1);
    chk("busy",  o_Busy,     m_act);
    chk("count", o_Count,    m_q.size());
    chk("full",  o_Full,     m_q.size() == DEPTH);
    chk("empty", o_Empty,    m_q.size() == 0);
    chk("ovf",   o_Overflow, m_ovf);
    if (o_Busy === 1'b1) busy_cycles++;
    if (prev_busy && o_Busy === 1'b0) busy_falls++;
    prev_busy = (o_Busy === 1'b1);
    if (!rst_n) begin
      d_cnt = -1;
    end else begin
      if (d_cnt < 0) begin
        if (o_TXD === 1'b0) d_cnt = 0;
      end else begin
        d_cnt++;
      end
      if (d_cnt >= 0 && (d_cnt % D) == D / 2) begin
        k = d_cnt / D;
        if (k >= 1 && k <= 8) d_byte[k-1] = o_TXD;
        if (k == 9) begin
          chk("rx_stop", o_TXD, 1'b1);
          rx.push_back(d_byte);
          d_cnt = -1;
        end
      end
    end
  end

  task automatic wait_pop(input int sz, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (m_act && m_t == FRAME - 1 && m_q.size() == sz) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_Busy === 1'b0 && o_Empty === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int   seq_a5[10];
    logic ok;
    seq_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    // Reset held with writes attempted
    i_WR = 1'b1; i_Data8 = 8'h3C;
    repeat (6) @(negedge clk);
    chk("rst_count", o_Count, 0);
    chk("rst_txd", o_TXD, 1);
    i_WR = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("rst_rx_none", rx.size(), 0);
    chk("rst_empty", o_Empty, 1);

    // Single byte 0xA5 with hand-computed line pattern
    @(negedge clk); i_WR = 1'b1; i_Data8 = 8'hA5;
    @(posedge clk); #2;
    chk("a5_cnt1", o_Count, 1);
    chk("a5_txd_pre", o_TXD, 1);
    @(negedge clk); i_WR = 1'b0; i_Data8 = 8'($urandom);
    for (int i = 0; i < FRAME; i++) begin
      @(posedge clk); #2;
      chk("a5_txd", o_TXD, seq_a5[i / D]);
      chk("a5_busy", o_Busy, 1);
    end
    @(posedge clk); #2;
    chk("a5_busy_end", o_Busy, 0);
    chk("a5_cnt0", o_Count, 0);
    repeat (8) @(negedge clk);
    chk("a5_rx_n", rx.size(), 1);
    if (rx.size() > 0) chk("a5_rx", rx[0], 8'hA5);
    rx.delete(); m_popped.delete();

    // Back-to-back frames, no gap
    busy_cycles = 0; busy_falls = 0;
    @(negedge clk); i_WR = 1'b1; i_Data8 = 8'h00;
    @(negedge clk); i_Data8 = 8'hFF;
    @(negedge clk); i_Data8 = 8'h55;
    @(negedge clk); i_WR = 1'b0;
    repeat (3 * FRAME + 20) @(negedge clk);
    chk("b2b_busy_cycles", busy_cycles, 3 * FRAME);
    chk("b2b_busy_falls", busy_falls, 1);
    chk("b2b_rx_n", rx.size(), 3);
    if (rx.size() == 3) begin
      chk("b2b_rx0", rx[0], 8'h00);
      chk("b2b_rx1", rx[1], 8'hFF);
      chk("b2b_rx2", rx[2], 8'h55);
    end
    rx.delete(); m_popped.delete();

    // Fill and overflow
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); i_WR = 1'b1; i_Data8 = 8'(i);
    end
    @(negedge clk); i_WR = 1'b0;
    chk("ovf_count8", o_Count, 8);
    chk("ovf_full", o_Full, 1);
    chk("ovf_set", o_Overflow, 1);
    i_WR = 1'b1; i_ClrOvf = 1'b1; i_Data8 = 8'h77;
    @(negedge clk); i_WR = 1'b0; i_ClrOvf = 1'b0;
    chk("ovf_set_wins", o_Overflow, 1);
    i_ClrOvf = 1'b1;
    @(negedge clk); i_ClrOvf = 1'b0;
    chk("ovf_cleared", o_Overflow, 0);

    wait_pop(8, 2 * FRAME + 5, ok);
    chk("pop8_found", ok, 1);
    i_WR = 1'b1; i_Data8 = 8'hBB;
    @(negedge clk); i_WR = 1'b0;
    chk("pop8_count7", o_Count, 7);
    chk("pop8_ovf", o_Overflow, 1);
    i_ClrOvf = 1'b1;
    @(negedge clk); i_ClrOvf = 1'b0;

    wait_pop(3, 6 * FRAME, ok);
    chk("pop3_found", ok, 1);
    i_WR = 1'b1; i_Data8 = 8'hEE;
    @(negedge clk); i_WR = 1'b0;
    chk("pop3_count3", o_Count, 3);
    chk("pop3_ovf", o_Overflow, 0);

    wait_idle(12 * FRAME, ok);
    chk("ovf_drained", ok, 1);
    chk("ovf_rx_n", rx.size(), 10);
    for (int i = 0; i < 9 && i < rx.size(); i++) chk("ovf_rx", rx[i], 8'(i + 1));
    if (rx.size() >= 10) chk("ovf_rx_last", rx[9], 8'hEE);
    rx.delete(); m_popped.delete();

    // Reset during data bit 4 of 0xC3 with two bytes still queued
    @(negedge clk); i_WR = 1'b1; i_Data8 = 8'hC3;
    @(negedge clk); i_Data8 = 8'h5A;
    @(negedge clk); i_Data8 = 8'h96;
    @(negedge clk); i_WR = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (m_act && m_t == 5 * D + 1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("mid_found", ok, 1);
    chk("mid_count2", o_Count, 2);
    chk("mid_c3_bit4", o_TXD, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_txd", o_TXD, 1);
    chk("mid_rst_count", o_Count, 0);
    chk("mid_rst_busy", o_Busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * FRAME) @(negedge clk);
    chk("mid_rx_none", rx.size(), 0);
    chk("mid_idle", o_Busy, 0);
    rx.delete(); m_popped.delete();

    // Randomized traffic
    repeat (400) begin
      @(negedge clk);
      i_WR     = ($urandom_range(0, 99) < 30);
      i_Data8  = 8'($urandom);
      i_ClrOvf = ($urandom_range(0, 99) < 5);
    end
    @(negedge clk); i_WR = 1'b0; i_ClrOvf = 1'b0;
    wait_idle((DEPTH + 2) * FRAME, ok);
    chk("rand_drained", ok, 1);
    chk("rand_rx_n", rx.size(), m_popped.size());
    for (int i = 0; i < rx.size() && i < m_popped.size(); i++) chk("rand_rx", rx[i], m_popped[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
